// File: rtl/wb_uart_rx_pkg.sv
// Shared constants for the Wishbone UART receiver.
//   state_t      : receive FSM states
//   ADR_*        : Wishbone word addresses of the data and status registers
//   STAT_*       : bit positions of the status register fields
package wb_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_STAT = 2'd1;

    localparam int STAT_NEMPTY = 31;
    localparam int STAT_OVR    = 30;
    localparam int STAT_FERR   = 29;

endpackage

// File: rtl/wb_uart_rx_if.sv
// Wishbone classic slave bus plus interrupt line of the UART receiver.
//   cyc_i, stb_i, we_i, adr_i[1:0], dat_i[31:0], sel_i[3:0] : master -> slave
//   ack_o, dat_o[31:0], irq_o                               : slave -> master
interface wb_uart_rx_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [1:0]  adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic [31:0] dat_o;
    logic        irq_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o, irq_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o, irq_o
    );
endinterface

// File: rtl/wb_uart_rx_fifo.sv
// Show-ahead FIFO: rdata presents the oldest entry while !empty.
//   clk, rst (active-high, synchronous), wr/wdata push, rd pop,
//   empty/full status. A write while full is accepted only when a read
//   happens on the same edge. SIZE must be a power of two.
module wb_uart_rx_fifo #(
    parameter int SIZE = 64,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [DW-1:0] mem [SIZE];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(SIZE));
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/wb_uart_rx.sv
// UART receiver (8N1, LSB first) with Wishbone slave and RX FIFO.
//   clk  : system clock
//   rst  : synchronous reset, active-low
//   rxd  : asynchronous serial input, idle high
//   bus  : Wishbone slave (adr 0 = RX data/pop, adr 1 = status/W1C),
//          irq_o high while the FIFO holds data
// One bit lasts DIV+1 clk cycles; bits are sampled at mid-bit.
module wb_uart_rx
    import wb_uart_rx_pkg::*;
#(
    parameter int DIV       = 861,
    parameter int CW        = $clog2(DIV + 1),
    parameter int FIFO_SIZE = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rxd,
    wb_uart_rx_if.slave  bus
);
    state_t        state;
    state_t        state_next;
    logic [1:0]    sync;
    logic          rxs;
    logic [CW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          tmr_clr;
    logic          shift;
    logic          push;
    logic          ferr_set;

    logic          acc;
    logic          pop;
    logic          ack;
    logic [31:0]   rdat;
    logic [31:0]   stat;
    logic          ovr;
    logic          ferr;
    logic          ovr_set;
    logic          ovr_clr;
    logic          ferr_clr;
    logic [7:0]    fifo_rdata;
    logic          empty;
    logic          full;
    logic          unused_bits;

    assign rxs = sync[1];

    always_ff @(posedge clk) begin
        if (!rst) sync <= '1;
        else      sync <= {sync[0], rxd};
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        tmr_clr    = 1'b0;
        shift      = 1'b0;
        push       = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            ST_IDLE:  if (!rxs) state_next = ST_START;
            ST_START: if (timer == CW'(DIV / 2)) state_next = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (timer == CW'(DIV)) begin
                          shift   = 1'b1;
                          tmr_clr = 1'b1;
                          if (bit_cnt == 3'd7) state_next = ST_STOP;
                      end
            ST_STOP:  if (timer == CW'(DIV)) begin
                          push       = rxs;
                          ferr_set   = ~rxs;
                          state_next = rxs ? ST_IDLE : ST_BRK;
                      end
            ST_BRK:   if (rxs) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (state_next != state) tmr_clr = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer   <= '0;
            bit_cnt <= '0;
            sh      <= '0;
        end else begin
            timer <= tmr_clr ? '0 : timer + CW'(1);
            if (state == ST_START) bit_cnt <= '0;
            else if (shift)        bit_cnt <= bit_cnt + 3'd1;
            if (shift) sh <= {rxs, sh[7:1]};
        end
    end

    wb_uart_rx_fifo #(
        .SIZE (FIFO_SIZE),
        .DW   (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (!rst),
        .wr    (push),
        .rd    (pop),
        .wdata (sh),
        .rdata (fifo_rdata),
        .empty (empty),
        .full  (full)
    );

    // acc is the single edge per access that raises ack; pop and W1C ride on it.
    assign acc      = bus.cyc_i & bus.stb_i & ~ack;
    assign pop      = acc & ~bus.we_i & (bus.adr_i == ADR_DATA) & ~empty;
    assign ovr_clr  = acc & bus.we_i & (bus.adr_i == ADR_STAT) & bus.dat_i[STAT_OVR];
    assign ferr_clr = acc & bus.we_i & (bus.adr_i == ADR_STAT) & bus.dat_i[STAT_FERR];
    // A same-edge pop frees the slot, so only a push into a full FIFO without pop overruns.
    assign ovr_set  = push & full & ~pop;

    always_comb begin
        stat              = '0;
        stat[STAT_NEMPTY] = ~empty;
        stat[STAT_OVR]    = ovr;
        stat[STAT_FERR]   = ferr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack  <= 1'b0;
            rdat <= '0;
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ack  <= acc;
            ovr  <= ovr_set  | (ovr  & ~ovr_clr);
            ferr <= ferr_set | (ferr & ~ferr_clr);
            if (acc) begin
                if (bus.we_i) begin
                    rdat <= '0;
                end else begin
                    case (bus.adr_i)
                        ADR_DATA: rdat <= empty ? '0 : {fifo_rdata, 24'h0};
                        ADR_STAT: rdat <= stat;
                        default:  rdat <= '0;
                    endcase
                end
            end
        end
    end

    assign bus.ack_o = ack;
    assign bus.dat_o = rdat;
    assign bus.irq_o = ~empty;

    assign unused_bits = ^{bus.sel_i, bus.dat_i[31], bus.dat_i[28:0]};
endmodule

// File: tb/tb_wb_uart_rx.sv
module tb_wb_uart_rx;
    logic clk;
    logic rst;
    logic rxd;
    int   n_checks;
    int   n_fail;

    wb_uart_rx_if bus ();

    wb_uart_rx #(
        .DIV       (15),
        .FIFO_SIZE (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame, 16 clk per bit; the stop level is left on the line.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(16);
        end
        rxd = stop;
        tick(16);
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        @(posedge clk);
        #1;
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = a;
        bus.dat_i = wd;
        bus.sel_i = 4'hF;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack_o) begin
                lat = i;
                rd  = bus.dat_o;
                break;
            end
        end
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        wb_xfer(1'b0, a, '0, d, lat);
        check(tag, d, exp);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] d;
        int          lat;
        wb_xfer(1'b1, a, wd, d, lat);
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        logic [7:0]  b;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        rxd       = 1'b1;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        bus.sel_i = '0;
        tick(4);
        check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
        check("rst_dat", bus.dat_o, 32'd0);
        check("rst_irq", {31'd0, bus.irq_o}, 32'd0);
        rst = 1'b1;
        tick(4);
        wb_read("rst_status", 2'd1, 32'h0000_0000);

        // 1: single frame, ack latency, irq drop after pop
        send_byte(8'hA5, 1'b1);
        tick(4);
        check("t1_irq_set", {31'd0, bus.irq_o}, 32'd1);
        wb_xfer(1'b0, 2'd0, '0, d, lat);
        check("t1_data", d, 32'hA500_0000);
        check("t1_ack_lat", lat, 32'd1);
        tick(1);
        check("t1_ack_drop", {31'd0, bus.ack_o}, 32'd0);
        check("t1_irq_clr", {31'd0, bus.irq_o}, 32'd0);
        wb_read("t1_empty_rd", 2'd0, 32'h0000_0000);

        // 2: short low glitch is rejected
        rxd = 1'b0;
        tick(6);
        rxd = 1'b1;
        tick(40);
        check("t2_irq", {31'd0, bus.irq_o}, 32'd0);
        wb_read("t2_status", 2'd1, 32'h0000_0000);

        // 3: framing error then break; one ferr only, cleared by W1C while still low
        send_byte(8'h3C, 1'b0);
        tick(40);
        wb_read("t3_status_ferr", 2'd1, 32'h2000_0000);
        wb_write(2'd1, 32'h2000_0000);
        tick(40);
        rxd = 1'b1;
        tick(40);
        check("t3_irq", {31'd0, bus.irq_o}, 32'd0);
        wb_read("t3_status_clr", 2'd1, 32'h0000_0000);

        // 4: overflow with depth 4
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_byte(b, 1'b1);
        end
        tick(4);
        wb_read("t4_status", 2'd1, 32'hC000_0000);
        wb_read("t4_adr2", 2'd2, 32'h0000_0000);
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            wb_read("t4_data", 2'd0, {b, 24'h0});
        end
        wb_read("t4_data5", 2'd0, 32'h0000_0000);
        check("t4_irq", {31'd0, bus.irq_o}, 32'd0);
        wb_write(2'd1, 32'h4000_0000);
        wb_read("t4_status_clr", 2'd1, 32'h0000_0000);

        // adr0 write is acked and has no effect
        wb_xfer(1'b1, 2'd0, 32'hFFFF_FFFF, d, lat);
        check("w0_ack_lat", lat, 32'd1);
        check("w0_irq", {31'd0, bus.irq_o}, 32'd0);

        // 5: back-to-back frames
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(4);
        wb_read("t5_status", 2'd1, 32'h8000_0000);
        wb_read("t5_data0", 2'd0, 32'h1100_0000);
        wb_read("t5_data1", 2'd0, 32'h2200_0000);
        wb_read("t5_status_end", 2'd1, 32'h0000_0000);

        // 6: reset during data bit 4 discards the partial byte
        b = 8'hE7;
        rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(16);
        end
        rxd = b[4];
        tick(8);
        rst = 1'b0;
        rxd = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(40);
        check("t6_irq", {31'd0, bus.irq_o}, 32'd0);
        wb_read("t6_status", 2'd1, 32'h0000_0000);
        send_byte(8'h7E, 1'b1);
        tick(4);
        check("t6_irq_new", {31'd0, bus.irq_o}, 32'd1);
        wb_read("t6_data", 2'd0, 32'h7E00_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
